// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift right, shift left, parallel load.
// Define USR_CLOCK_ENABLE_EN to add a ce port that freezes Q when low.
module universal_shift_register #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef USR_CLOCK_ENABLE_EN
    input  logic             ce,
`endif
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] In,
    input  logic             new_at_left,
    input  logic             new_at_right,
    output logic [WIDTH-1:0] Out
);

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic             en;

`ifdef USR_CLOCK_ENABLE_EN
    assign en = ce;
`else
    assign en = 1'b1;
`endif

    // Each mode reads only its own data input, so unused inputs cannot leak X into Q.
    always_comb begin
        q_next = q;
        if (en) begin
            case (sel)
                SEL_HOLD: q_next = q;
                SEL_SHR:  q_next = {new_at_left, q[WIDTH-1:1]};
                SEL_SHL:  q_next = {q[WIDTH-2:0], new_at_right};
                SEL_LOAD: q_next = In;
                default:  q_next = q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else      q <= q_next;
    end

    assign Out = q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register (WIDTH=4).
module tb_universal_shift_register;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic [3:0] In;
    logic       new_at_left;
    logic       new_at_right;
    logic [3:0] Out;
`ifdef USR_CLOCK_ENABLE_EN
    logic       ce = 1'b1;
`endif

    int checks = 0;
    int errors = 0;

    universal_shift_register #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef USR_CLOCK_ENABLE_EN
        .ce           (ce),
`endif
        .sel          (sel),
        .In           (In),
        .new_at_left  (new_at_left),
        .new_at_right (new_at_right),
        .Out          (Out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] fill_r [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    logic [3:0] fill_l [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [3:0] over_l [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111};

    initial begin
        rst = 1'b0; sel = 2'b00; In = 4'b0000; new_at_left = 1'b0; new_at_right = 1'b0;
        #10;
        chk("reset_idle", Out, 4'b0000);

        // Reset dominates a requested load across several edges.
        sel = 2'b11; In = 4'b1111;
        tick(); tick();
        chk("reset_dominates_load", Out, 4'b0000);

        // First edge after release performs the load.
        rst = 1'b1; In = 4'b1010;
        tick();
        chk("load_1010", Out, 4'b1010);

        sel = 2'b00; In = 4'b1111;
        tick();
        chk("hold_ignores_in", Out, 4'b1010);

        sel = 2'b01; new_at_left = 1'b1; In = 4'bxxxx; new_at_right = 1'bx;
        tick();
        chk("shr_1101", Out, 4'b1101);

        sel = 2'b10; new_at_right = 1'b0; new_at_left = 1'bx;
        tick();
        chk("shl_1010", Out, 4'b1010);

        new_at_right = 1'b1;
        tick();
        chk("shl_0101", Out, 4'b0101);

        sel = 2'b00; new_at_right = 1'bx; In = 4'bxxxx;
        tick();
        chk("hold_0101", Out, 4'b0101);

        // Input wiggles between edges must not disturb Q.
        sel = 2'b11; In = 4'b0000; #2;
        sel = 2'b00; #1;
        chk("no_midcycle_effect", Out, 4'b0101);

        // Asynchronous clear mid-cycle after a load.
        sel = 2'b11; In = 4'b1111;
        tick();
        chk("load_1111", Out, 4'b1111);
        #2 rst = 1'b0;
        #1 chk("async_clear_midcycle", Out, 4'b0000);
        sel = 2'b00; In = 4'b0000;
        #1 rst = 1'b1;

        sel = 2'b01; new_at_left = 1'b1; new_at_right = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("fill_right_%0d", i), Out, fill_r[i]);
        end

        sel = 2'b10; new_at_right = 1'b0; new_at_left = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("fill_left_%0d", i), Out, fill_l[i]);
        end

        // Shifting past WIDTH keeps filling, no wrap-around.
        new_at_right = 1'b1; new_at_left = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("overshift_left_%0d", i), Out, over_l[i]);
        end

        sel = 2'b01; new_at_left = 1'b0;
        tick();
        chk("shr_discard_lsb", Out, 4'b0111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parameterised universal shift register with four modes: hold, shift right, shift left and parallel load.
- Used as a general-purpose storage and serialisation element.
- Mode is chosen each cycle by a 2-bit select.
- Output is the register state directly, with no combinational path from inputs.

Parameters:
- WIDTH, 4, number of register bits (must be at least 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- sel  input  2  mode select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- In  input  WIDTH  parallel load data.
- new_at_left  input  1  serial bit entering the MSB on shift right.
- new_at_right  input  1  serial bit entering the LSB on shift left.
- Out  output  WIDTH  current register contents.

Behaviour:
- Single register Q[WIDTH-1:0]; Out = Q at all times.
- Reset:
  - rst low clears Q to all zeros immediately, without waiting for a clock edge.
  - Q stays zero while rst is low, regardless of clk or other inputs.
  - rst has priority over every mode.
- rst release: the first rising clk edge after rst goes high performs the selected operation.
- Operation on each rising clk edge with rst high:
  - sel=00 hold: Q unchanged.
  - sel=01 shift right: Q <= {new_at_left, Q[WIDTH-1:1]}. Old Q[0] is discarded.
  - sel=10 shift left: Q <= {Q[WIDTH-2:0], new_at_right}. Old Q[WIDTH-1] is discarded.
  - sel=11 parallel load: Q <= In.
- Input sampling: inputs are sampled only at the rising edge. Changes between edges have no effect.
- Latency: one clock. Out reflects the operation after the sampling edge.
- Unused inputs per mode are don't-care:
  - In is ignored unless sel=11.
  - new_at_left is ignored unless sel=01.
  - new_at_right is ignored unless sel=10.
- No X propagation from unused inputs.
- Repeated shifts: WIDTH consecutive shifts fully replace contents with serial input bits. Shifting beyond WIDTH has no wrap-around; it continues filling from the serial input.
- No handshake, no status flags, no internal state beyond Q.

Optional Feature:
- Macro: USR_CLOCK_ENABLE_EN.
- Defined:
  - Adds input port ce (1 bit), placed after rst.
  - When ce=0 at a rising edge, Q holds regardless of sel.
  - When ce=1, normal sel behaviour applies.
  - Reset still clears Q asynchronously regardless of ce.
- Not defined:
  - No ce port.
  - The register operates on every rising edge per sel.

Test Plan:
- Reset: rst=0, sel=00, In=0000 for 10 ns -> Out=0000. Assert rst=0 mid-cycle after a load -> Out=0000 immediately, before the next edge.
- Parallel load: rst=1, sel=11, In=1010, one edge -> Out=1010.
- Hold: sel=00, In changed to 1111, one edge -> Out stays 1010.
- Shift right: from 1010, sel=01, new_at_left=1, one edge -> Out=1101.
- Shift left, two edges from 1101 with sel=10:
  - new_at_right=0 -> Out=1010.
  - then new_at_right=1 -> Out=0101.
  - then sel=00 -> Out stays 0101.
- Fill: from 0000, sel=01, new_at_left=1 for WIDTH edges -> Out=1111. Then sel=10, new_at_right=0 for WIDTH edges -> Out=0000.
